// File: rtl/regfile_sb.sv
// Multi-read, dual-write architectural register file with a per-register busy
// scoreboard that produces RAW/WAW stall indications for decode.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    input  logic [NRD-1:0]      ra_used,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREG-1:0]     busy_vec,
    output logic                raw_hazard,
    output logic                waw_hazard
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] eb;
    logic [NRD-1:0]  raw_port;

    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;

    assign wr0_ok = we0 && !(HAS_ZERO && wa0 == '0);
    assign wr1_ok = we1 && !(HAS_ZERO && wa1 == '0);
    assign iss_ok = issue_valid && !(HAS_ZERO && issue_rd == '0);

    // Port 1 is applied first so a same-address port 0 write overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr1_ok) begin
                mem[wa1] <= wd1;
            end
            if (wr0_ok) begin
                mem[wa0] <= wd0;
            end
            busy <= busy_next;
        end
    end

    // Set is applied after the clears so a newly issued producer wins.
    always_comb begin
        busy_next = busy;
        if (we0) begin
            busy_next[wa0] = 1'b0;
        end
        if (we1) begin
            busy_next[wa1] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        eb = '0;
        for (int i = 0; i < NREG; i++) begin
            eb[i] = busy[i] && !(HAS_BYP && ((we0 && wa0 == AW'(i)) ||
                                             (we1 && wa1 == AW'(i))));
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;

        assign addr    = ra[k*AW +: AW];
        assign is_zero = HAS_ZERO && addr == '0;

        assign rd[k*XLEN +: XLEN] = is_zero                         ? '0  :
                                    (HAS_BYP && we0 && wa0 == addr) ? wd0 :
                                    (HAS_BYP && we1 && wa1 == addr) ? wd1 :
                                                                      mem[addr];

        assign raw_port[k] = ra_used[k] && eb[addr] && !is_zero;
    end

    assign busy_vec   = busy;
    assign raw_hazard = |raw_port;
    assign waw_hazard = issue_valid && eb[issue_rd] && !(HAS_ZERO && issue_rd == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs, a monitor
// drains the queue on the falling edge and compares against the DUT.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_RAW  = 2;
    localparam int K_WAW  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                we0, we1;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic [NRD*AW-1:0]   ra;
    logic [NRD-1:0]      ra_used;
    logic [NRD*XLEN-1:0] rd;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic [NREG-1:0]     busy_vec;
    logic                raw_hazard;
    logic                waw_hazard;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .ra_used(ra_used), .rd(rd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_vec(busy_vec), .raw_hazard(raw_hazard), .waw_hazard(waw_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_val(input string name, input int kind, input int idx,
                              input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        ra = '0; ra_used = '0;
        issue_valid = 0; issue_rd = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    initial begin : monitor
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.kind)
                    K_RD:    act = rd[c.idx*XLEN +: XLEN];
                    K_BUSY:  act = busy_vec;
                    K_RAW:   act = {31'b0, raw_hazard};
                    default: act = {31'b0, waw_hazard};
                endcase
                n_checks++;
                if (act === c.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int budget;
        idle();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;

        // Reset contents on every address, both ports, all sources used
        for (int a = 0; a < NREG; a++) begin
            set_ra(a, NREG - 1 - a);
            ra_used = 2'b11;
            expect_val("reset_rd0", K_RD, 0, 32'h0);
            expect_val("reset_rd1", K_RD, 1, 32'h0);
            if (a == 0) begin
                expect_val("reset_busy", K_BUSY, 0, 32'h0);
                expect_val("reset_raw", K_RAW, 0, 32'h0);
                issue_valid = 1; issue_rd = 5'd0;
                expect_val("reset_waw", K_WAW, 0, 32'h0);
            end
            next_cycle();
        end
        // Issue to r0 above must not have set anything
        expect_val("zero_issue_busy", K_BUSY, 0, 32'h0);

        // Write bypass and post-write read
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; set_ra(5, 0);
        expect_val("bypass_rd0", K_RD, 0, 32'hDEADBEEF);
        expect_val("bypass_rd1_zero", K_RD, 1, 32'h0);
        next_cycle();
        set_ra(5, 5);
        expect_val("after_wr_rd0", K_RD, 0, 32'hDEADBEEF);
        expect_val("after_wr_rd1", K_RD, 1, 32'hDEADBEEF);
        next_cycle();

        // Collision: port 0 wins; then write to r0 ignored
        we0 = 1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h22;
        set_ra(7, 7);
        expect_val("collide_byp_rd0", K_RD, 0, 32'h11);
        next_cycle();
        we0 = 1; wa0 = 5'd0; wd0 = 32'h33; set_ra(0, 7);
        expect_val("r0_byp_rd0", K_RD, 0, 32'h0);
        expect_val("collide_rd1", K_RD, 1, 32'h11);
        next_cycle();
        we1 = 1; wa1 = 5'd0; wd1 = 32'h44; set_ra(7, 0);
        expect_val("collide_rd0", K_RD, 0, 32'h11);
        expect_val("r0_wr1_rd1", K_RD, 1, 32'h0);
        next_cycle();
        set_ra(0, 0);
        expect_val("r0_after_rd0", K_RD, 0, 32'h0);
        expect_val("r0_after_rd1", K_RD, 1, 32'h0);
        next_cycle();

        // Scoreboard: RAW/WAW on reg 3
        issue_valid = 1; issue_rd = 5'd3;
        expect_val("issue3_waw_first", K_WAW, 0, 32'h0);
        next_cycle();
        set_ra(3, 0); ra_used = 2'b01;
        expect_val("busy3_set", K_BUSY, 0, 32'h0000_0008);
        expect_val("raw_port0", K_RAW, 0, 32'h1);
        next_cycle();
        set_ra(3, 0); ra_used = 2'b00;
        expect_val("raw_unused", K_RAW, 0, 32'h0);
        next_cycle();
        set_ra(1, 3); ra_used = 2'b10;
        expect_val("raw_port1", K_RAW, 0, 32'h1);
        next_cycle();
        set_ra(3, 3); ra_used = 2'b01;
        issue_valid = 1; issue_rd = 5'd3;
        expect_val("waw_busy", K_WAW, 0, 32'h1);
        next_cycle();

        // Writeback clears busy, bypass masks hazard
        we1 = 1; wa1 = 5'd3; wd1 = 32'h55; set_ra(3, 0); ra_used = 2'b01;
        expect_val("wb_raw_masked", K_RAW, 0, 32'h0);
        expect_val("wb_byp_rd0", K_RD, 0, 32'h55);
        next_cycle();
        set_ra(3, 0);
        expect_val("wb_busy_clear", K_BUSY, 0, 32'h0);
        expect_val("wb_rd0", K_RD, 0, 32'h55);
        issue_valid = 1; issue_rd = 5'd3;
        next_cycle();
        we1 = 1; wa1 = 5'd3; wd1 = 32'h66;
        issue_valid = 1; issue_rd = 5'd3;
        expect_val("waw_masked_by_wb", K_WAW, 0, 32'h0);
        next_cycle();
        expect_val("set_wins", K_BUSY, 0, 32'h0000_0008);
        we0 = 1; wa0 = 5'd3; wd0 = 32'h99;
        next_cycle();
        set_ra(3, 0);
        expect_val("wb0_busy_clear", K_BUSY, 0, 32'h0);
        expect_val("wb0_rd0", K_RD, 0, 32'h99);
        next_cycle();

        // Reset discards busy bits and contents, including a same-cycle write
        issue_valid = 1; issue_rd = 5'd2;
        next_cycle();
        issue_valid = 1; issue_rd = 5'd9;
        we0 = 1; wa0 = 5'd4; wd0 = 32'h77;
        next_cycle();
        set_ra(4, 0);
        expect_val("pre_rst_busy", K_BUSY, 0, 32'h0000_0204);
        expect_val("pre_rst_rd4", K_RD, 0, 32'h77);
        next_cycle();
        rst = 1;
        we0 = 1; wa0 = 5'd6; wd0 = 32'hAB;
        next_cycle();
        rst = 0;
        set_ra(4, 6); ra_used = 2'b11;
        expect_val("post_rst_busy", K_BUSY, 0, 32'h0);
        expect_val("post_rst_rd4", K_RD, 0, 32'h0);
        expect_val("post_rst_rd6", K_RD, 1, 32'h0);
        expect_val("post_rst_raw", K_RAW, 0, 32'h0);
        next_cycle();

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read, dual-write register file with an integrated scoreboard, serving as the architectural register file of the pipelined RISC-V core. It accepts writebacks from two sources: port 0 for the ALU/mem writeback and port 1 for a long-latency unit. Optional write-to-read bypass is built in. A per-register busy bit tracks in-flight producers and generates RAW/WAW stall signals for decode.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers (power of 2, >=2)
AW, $clog2(NREG), register address width (derived, not overridden)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, writes and issues to it ignored
BYPASS, 1, 1 = same-cycle writeback data forwarded to reads and busy cleared for hazard check

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
we0  in  1  write enable, port 0 (higher priority)
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
ra  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
ra_used  in  NRD  port k operand is actually consumed by the issuing instruction
rd  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  AW  destination of issuing instruction
busy_vec  out  NREG  registered busy bits
raw_hazard  out  1  some used source is busy
waw_hazard  out  1  issue_rd is busy

Behaviour:
- Reset: reset is rst, synchronous, active-high; clock is clk. On a clk edge with rst=1, all registers are set to 0 and busy_vec is set to 0. Writes and issues in that cycle are ignored. Reset mid-operation discards all pending state.
- Write: at posedge, if weN=1 (and not (ZERO_REG && waN==0)), then mem[waN] <= wdN.
- Write collision: if both ports write the same address in one cycle, port 0 data lands and port 1 data is dropped. Different addresses are both written.
- Read: combinational, zero latency.
  - ZERO_REG && ra_k==0 -> 0.
  - Else if BYPASS and we0 && wa0==ra_k -> wd0.
  - Else if BYPASS and we1 && wa1==ra_k -> wd1.
  - Else mem[ra_k].
  - BYPASS=0 -> new data is visible on the cycle after the write.
- Scoreboard:
  - A write on either port clears busy[waN] at posedge.
  - issue_valid=1 sets busy[issue_rd] at posedge, unless ZERO_REG && issue_rd==0.
  - Set and clear on the same register in the same cycle: set wins (a new producer has been issued).
- Effective busy eb[i] = busy[i] && !(BYPASS && ((we0&&wa0==i)||(we1&&wa1==i))).
- raw_hazard = OR over k of (ra_used[k] && eb[ra_k] && !(ZERO_REG && ra_k==0)). Combinational.
- waw_hazard = issue_valid && eb[issue_rd] && !(ZERO_REG && issue_rd==0). Combinational.
- Gating: the block does not itself gate issue_valid on hazards; decode must drop issue_valid while either hazard is 1.
- ZERO_REG=0: register 0 behaves like any other register.
- Width rules: addresses >= NREG cannot occur (NREG is a power of 2); no truncation or extension of data.

Test Plan:
- Reset then read all addresses on both ports -> rd=0, busy_vec=0, raw_hazard=0, waw_hazard=0.
- we0=1, wa0=5, wd0=0xDEADBEEF with ra[0]=5 in the same cycle, BYPASS=1 -> rd0=0xDEADBEEF that cycle and after the edge. With BYPASS=1 and ra[1]=0 -> rd1=0.
- Same-cycle we0 to reg 7 with 0x11 and we1 to reg 7 with 0x22 -> reg 7 = 0x11 next cycle. Write of 0x33 to reg 0 -> reads stay 0.
- issue_valid, issue_rd=3 -> busy_vec[3]=1. Next cycle ra[0]=3, ra_used=01 -> raw_hazard=1. Same with ra_used=00 -> raw_hazard=0. issue_rd=3 again -> waw_hazard=1.
- Busy reg 3, then we1=1, wa1=3, wd1=0x55 with ra[0]=3 used -> raw_hazard=0, rd0=0x55, busy_vec[3]=0 next cycle. Same cycle plus issue_valid, issue_rd=3 -> busy_vec[3]=1 (set wins).
- Busy regs 2 and 9 set, write reg 4 = 0x77, then assert rst for 1 cycle while we0 writes reg 6 -> busy_vec=0, regs 4 and 6 read 0.
